// File: rtl/lap_timer_pkg.sv
// Shared types and helpers for the lap_timer mm:ss stopwatch/countdown block.
package lap_timer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_t;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef logic [15:0]        lap_t;

  // Saturate each nibble at 9 first, then the two-digit value at max_val.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input int unsigned max_val);
    int unsigned tens;
    int unsigned ones;
    int unsigned val;
    tens = (v[7:4] > 4'd9) ? 32'd9 : 32'(v[7:4]);
    ones = (v[3:0] > 4'd9) ? 32'd9 : 32'(v[3:0]);
    val  = tens * 10 + ones;
    if (val > max_val) val = max_val;
    return {bcd_t'(val / 10), bcd_t'(val % 10)};
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss counter with up/down stepping, wrap at MAX_MIN:59 and preset load.
module bcd_mmss_counter
  import lap_timer_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic clk1sec,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  lap_t load_val,
  input  logic tick,
  input  logic down,
  output lap_t cur_time,
  output logic at_max,
  output logic at_zero,
  output logic at_one
);

  localparam bcd_t MAX_TENS = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX_MIN % 10);

  lap_t cur_q, cur_d;
  bcd_t tm_q, om_q, ts_q, os_q;
  bcd_t tm_d, om_d, ts_d, os_d;

  assign {tm_q, om_q, ts_q, os_q} = cur_q;
  assign cur_time = cur_q;
  assign at_max   = (tm_q == MAX_TENS) && (om_q == MAX_ONES) && (ts_q == 4'd5) && (os_q == 4'd9);
  assign at_zero  = (cur_q == 16'h0000);
  assign at_one   = (cur_q == 16'h0001);

  // Carry/borrow ripple: seconds ones 0..9, seconds tens 0..5, minutes plain BCD.
  always_comb begin
    tm_d = tm_q;
    om_d = om_q;
    ts_d = ts_q;
    os_d = os_q;
    if (clear) begin
      {tm_d, om_d, ts_d, os_d} = 16'h0000;
    end else if (load) begin
      {tm_d, om_d, ts_d, os_d} = load_val;
    end else if (tick && !down) begin
      if (at_max) begin
        {tm_d, om_d, ts_d, os_d} = 16'h0000;
      end else if (os_q != 4'd9) begin
        os_d = os_q + 4'd1;
      end else begin
        os_d = 4'd0;
        if (ts_q != 4'd5) begin
          ts_d = ts_q + 4'd1;
        end else begin
          ts_d = 4'd0;
          if (om_q != 4'd9) begin
            om_d = om_q + 4'd1;
          end else begin
            om_d = 4'd0;
            tm_d = tm_q + 4'd1;
          end
        end
      end
    end else if (tick && down && !at_zero) begin
      if (os_q != 4'd0) begin
        os_d = os_q - 4'd1;
      end else begin
        os_d = 4'd9;
        if (ts_q != 4'd0) begin
          ts_d = ts_q - 4'd1;
        end else begin
          ts_d = 4'd5;
          if (om_q != 4'd0) begin
            om_d = om_q - 4'd1;
          end else begin
            om_d = 4'd9;
            tm_d = tm_q - 4'd1;
          end
        end
      end
    end
    cur_d = {tm_d, om_d, ts_d, os_d};
  end

  always_ff @(posedge clk1sec or posedge rst) begin
    if (rst) cur_q <= '0;
    else     cur_q <= cur_d;
  end

endmodule

// File: rtl/lap_timer.sv
// Up/down mm:ss lap timer: run/pause FSM, preset load, countdown expiry and lap-capture FIFO.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int MAX_MIN   = 59,
  parameter int LAP_DEPTH = 4,
  parameter int DOWN_EN   = 1
) (
  input  logic                       clk1sec,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start_stop,
  input  logic                       lap,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       mode_down,
  input  logic [7:0]                 load_min,
  input  logic [7:0]                 load_sec,
  output logic [3:0]                 tenmin,
  output logic [3:0]                 onemin,
  output logic [3:0]                 tensec,
  output logic [3:0]                 onesec,
  output logic                       running,
  output logic                       expired,
  output logic                       wrapped,
  input  logic                       lap_rd,
  output logic [15:0]                lap_data,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic                       lap_ovf
);

  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              wrapped_q, wrapped_d;
  logic              lap_ovf_q, lap_ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lap_t              mem_q [LAP_DEPTH];
  lap_t              mem_d [LAP_DEPTH];
  lap_t              lap_data_q, lap_data_d;

  logic clear_ev, load_ev, ss_ev, tick, new_mode;
  logic lap_acc, pop, push, full;
  logic at_max, at_zero, at_one;
  lap_t cur_time, load_val;

  assign new_mode = (DOWN_EN != 0) && mode_down;
  assign load_val = {clamp_bcd(load_min, MAX_MIN), clamp_bcd(load_sec, 59)};

  // Event decode in priority order; load is honoured out of EXPIRED so a preset can leave it.
  always_comb begin
    clear_ev = en && clear;
    load_ev  = en && load && !clear_ev && (state_q != ST_RUN);
    ss_ev    = en && start_stop && !clear_ev && !load_ev && (state_q != ST_EXPIRED);
    tick     = (state_q == ST_RUN) && !clear_ev && !ss_ev;
  end

  bcd_mmss_counter #(.MAX_MIN(MAX_MIN)) u_counter (
    .clk1sec  (clk1sec),
    .rst      (rst),
    .clear    (clear_ev),
    .load     (load_ev),
    .load_val (load_val),
    .tick     (tick),
    .down     (mode_q),
    .cur_time (cur_time),
    .at_max   (at_max),
    .at_zero  (at_zero),
    .at_one   (at_one)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wrapped_d = wrapped_q;
    if (clear_ev) begin
      state_d   = ST_IDLE;
      mode_d    = new_mode;
      wrapped_d = 1'b0;
    end else if (load_ev) begin
      if (state_q == ST_EXPIRED) state_d = ST_IDLE;
      mode_d    = new_mode;
      wrapped_d = 1'b0;
    end else if (ss_ev) begin
      if (state_q == ST_RUN)        state_d = ST_PAUSED;
      else if (mode_q && at_zero)   state_d = ST_EXPIRED;
      else                          state_d = ST_RUN;
    end else if (tick) begin
      if (mode_q && at_one)         state_d = ST_EXPIRED;
      else if (!mode_q && at_max)   wrapped_d = 1'b1;
    end
  end

  // A pop frees a slot in the same edge, so a full FIFO can still accept a lap alongside a read.
  always_comb begin
    lap_acc    = en && lap && ((state_q == ST_RUN) || (state_q == ST_PAUSED));
    full       = (cnt_q == CNT_W'(LAP_DEPTH));
    pop        = lap_rd && (cnt_q != '0);
    push       = lap_acc && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    lap_data_d = lap_data_q;
    lap_ovf_d  = lap_ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = cur_time;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      lap_data_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (clear_ev)                  lap_ovf_d = 1'b0;
    else if (lap_acc && full && !pop) lap_ovf_d = 1'b1;
  end

  always_ff @(posedge clk1sec or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      lap_ovf_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      mem_q      <= '{default: '0};
      lap_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wrapped_q  <= wrapped_d;
      lap_ovf_q  <= lap_ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      lap_data_q <= lap_data_d;
    end
  end

  assign {tenmin, onemin, tensec, onesec} = cur_time;
  assign running   = (state_q == ST_RUN);
  assign expired   = (state_q == ST_EXPIRED);
  assign wrapped   = wrapped_q;
  assign lap_data  = lap_data_q;
  assign lap_count = cnt_q;
  assign lap_ovf   = lap_ovf_q;

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: directed scenarios plus random stimulus against a seconds-based model.
module tb_lap_timer;

  localparam int MAX_MIN   = 59;
  localparam int LAP_DEPTH = 4;
  localparam int TOTAL     = (MAX_MIN + 1) * 60;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic        clk1sec = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        start_stop = 1'b0, lap = 1'b0, clear = 1'b0, load = 1'b0, mode_down = 1'b0;
  logic [7:0]  load_min = 8'h00, load_sec = 8'h00;
  logic        lap_rd = 1'b0;
  logic [3:0]  tenmin, onemin, tensec, onesec;
  logic        running, expired, wrapped, lap_ovf;
  logic [15:0] lap_data;
  logic [$clog2(LAP_DEPTH):0] lap_count;

  int tests_run = 0;
  int tests_failed = 0;

  int m_state, m_t, m_lapdata;
  bit m_down, m_wrapped, m_ovf;
  int m_q[$];

  always #5 clk1sec = ~clk1sec;

  lap_timer #(.MAX_MIN(MAX_MIN), .LAP_DEPTH(LAP_DEPTH), .DOWN_EN(1)) dut (
    .clk1sec(clk1sec), .rst(rst), .en(en), .start_stop(start_stop), .lap(lap),
    .clear(clear), .load(load), .mode_down(mode_down), .load_min(load_min),
    .load_sec(load_sec), .tenmin(tenmin), .onemin(onemin), .tensec(tensec),
    .onesec(onesec), .running(running), .expired(expired), .wrapped(wrapped),
    .lap_rd(lap_rd), .lap_data(lap_data), .lap_count(lap_count), .lap_ovf(lap_ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int clamp_load(input logic [7:0] mn, input logic [7:0] sc);
    int mt, mo, st, so, m, s;
    mt = (mn[7:4] > 4'd9) ? 9 : int'(mn[7:4]);
    mo = (mn[3:0] > 4'd9) ? 9 : int'(mn[3:0]);
    st = (sc[7:4] > 4'd9) ? 9 : int'(sc[7:4]);
    so = (sc[3:0] > 4'd9) ? 9 : int'(sc[3:0]);
    m = mt * 10 + mo;
    s = st * 10 + so;
    if (m > MAX_MIN) m = MAX_MIN;
    if (s > 59) s = 59;
    return m * 60 + s;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_t = 0; m_lapdata = 0;
    m_down = 0; m_wrapped = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit c, l, s, lap_ok, do_pop;
    int t_before;
    t_before = m_t;
    c = en && clear;
    l = en && load && !c && (m_state != M_RUN);
    s = en && start_stop && !c && !l && (m_state != M_EXP);
    lap_ok = en && lap && (m_state == M_RUN || m_state == M_PAUSED);
    do_pop = lap_rd && (m_q.size() > 0);
    if (do_pop) m_lapdata = m_q.pop_front();
    if (lap_ok) begin
      if (m_q.size() < LAP_DEPTH) m_q.push_back(t_before);
      else m_ovf = 1;
    end
    if (c) begin
      m_state = M_IDLE; m_t = 0; m_down = mode_down; m_wrapped = 0; m_ovf = 0;
    end else if (l) begin
      m_t = clamp_load(load_min, load_sec);
      m_down = mode_down; m_wrapped = 0;
      if (m_state == M_EXP) m_state = M_IDLE;
    end else if (s) begin
      if (m_state == M_RUN) m_state = M_PAUSED;
      else if (m_down && m_t == 0) m_state = M_EXP;
      else m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_down) begin
        m_t = m_t - 1;
        if (m_t == 0) m_state = M_EXP;
      end else if (m_t == TOTAL - 1) begin
        m_t = 0; m_wrapped = 1;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  function automatic logic [15:0] shown();
    return {tenmin, onemin, tensec, onesec};
  endfunction

  task automatic compare_all();
    checkOutput("time", 32'(shown()), 32'(to_bcd(m_t)));
    checkOutput("running", 32'(running), 32'(m_state == M_RUN));
    checkOutput("expired", 32'(expired), 32'(m_state == M_EXP));
    checkOutput("wrapped", 32'(wrapped), 32'(m_wrapped));
    checkOutput("lap_count", 32'(lap_count), 32'(m_q.size()));
    checkOutput("lap_ovf", 32'(lap_ovf), 32'(m_ovf));
    checkOutput("lap_data", 32'(lap_data), 32'(to_bcd(m_lapdata)));
  endtask

  task automatic applyStimulus();
    @(posedge clk1sec);
    model_step();
    #1;
    compare_all();
    start_stop = 0; lap = 0; clear = 0; load = 0; lap_rd = 0;
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    @(posedge clk1sec);
    #1 rst = 0;

    // Run 75 s, then pause and hold.
    start_stop = 1; applyStimulus();
    repeat (75) applyStimulus();
    checkOutput("run_0115", 32'(shown()), 32'h0115);
    checkOutput("run_flag", 32'(running), 32'd1);
    start_stop = 1; applyStimulus();
    repeat (10) applyStimulus();
    checkOutput("pause_hold", 32'(shown()), 32'h0115);

    // Up-count wrap from 59:58.
    clear = 1; applyStimulus();
    load = 1; mode_down = 0; load_min = 8'h59; load_sec = 8'h58; applyStimulus();
    start_stop = 1; applyStimulus();
    applyStimulus(); checkOutput("wrap_5959", 32'(shown()), 32'h5959);
    applyStimulus(); checkOutput("wrap_0000", 32'(shown()), 32'h0000);
    applyStimulus(); checkOutput("wrap_0001", 32'(shown()), 32'h0001);
    checkOutput("wrap_flag", 32'(wrapped), 32'd1);

    // Countdown to expiry.
    clear = 1; applyStimulus();
    load = 1; mode_down = 1; load_min = 8'h00; load_sec = 8'h03; applyStimulus();
    mode_down = 0;
    start_stop = 1; applyStimulus();
    applyStimulus(); checkOutput("down_0002", 32'(shown()), 32'h0002);
    applyStimulus(); checkOutput("down_0001", 32'(shown()), 32'h0001);
    applyStimulus(); checkOutput("down_0000", 32'(shown()), 32'h0000);
    checkOutput("down_expired", 32'(expired), 32'd1);
    start_stop = 1; applyStimulus();
    checkOutput("exp_ignore_ss", 32'(expired), 32'd1);
    clear = 1; applyStimulus();
    checkOutput("clear_idle", 32'({running, expired}), 32'd0);

    // Illegal preset clamps.
    load = 1; load_min = 8'h7A; load_sec = 8'h99; applyStimulus();
    checkOutput("clamp_5959", 32'(shown()), 32'h5959);

    // Lap FIFO overflow and ordered pops.
    clear = 1; applyStimulus();
    start_stop = 1; applyStimulus();
    applyStimulus();
    repeat (5) begin lap = 1; applyStimulus(); end
    checkOutput("lap_count4", 32'(lap_count), 32'd4);
    checkOutput("lap_ovf_set", 32'(lap_ovf), 32'd1);
    start_stop = 1; applyStimulus();
    for (int i = 1; i <= 4; i++) begin
      lap_rd = 1; applyStimulus();
      checkOutput("lap_pop", 32'(lap_data), 32'(i));
    end

    // Asynchronous reset between edges while running.
    start_stop = 1; applyStimulus();
    repeat (7) applyStimulus();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    checkOutput("rst_time", 32'(shown()), 32'h0000);
    #1 rst = 0;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      en         = ($urandom_range(0, 7) != 0);
      start_stop = ($urandom_range(0, 7) == 0);
      lap        = ($urandom_range(0, 5) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      load       = ($urandom_range(0, 24) == 0);
      mode_down  = $urandom_range(0, 1);
      load_min   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      load_sec   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      lap_rd     = ($urandom_range(0, 5) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
